// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and op-class helpers for the iterative mul/div unit
package muldiv_pkg;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} md_state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
  function automatic logic is_signed_a(input logic [2:0] op);
    return op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM;
  endfunction
  function automatic logic is_signed_b(input logic [2:0] op);
    return op == MD_MULH || op == MD_DIV || op == MD_REM;
  endfunction
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negate
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);
  assign dout = neg ? -din : din;
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RISC-V M-extension multiply/divide; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  md_state_t         state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, mcand, ma, mb, fix_res;
  logic [2*XLEN-1:0] acc, acc_nxt, fix_in, fix_out, fast_prod;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN:0]     div_sh, div_sub, mul_sum;
  logic              neg_q, sa, sb, div_zero, div_ovf, fast;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign sa = is_signed_a(op_q) & a_q[XLEN-1];
  assign sb = is_signed_b(op_q) & b_q[XLEN-1];
  muldiv_negate #(.W(XLEN)) u_neg_a (.din(a_q), .neg(sa), .dout(ma));
  muldiv_negate #(.W(XLEN)) u_neg_b (.din(b_q), .neg(sb), .dout(mb));
  assign div_zero = is_div(op_q) && b_q == '0;
  assign div_ovf  = is_div(op_q) && !op_q[0] && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1;
`ifdef MULDIV_FAST_MUL_EN
  assign fast      = !is_div(op_q);
  assign fast_prod = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
`else
  assign fast      = 1'b0;
  assign fast_prod = '0;
`endif
  // one iteration: shift-add for multiply, restoring subtract with guard bit for divide
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? mcand : {XLEN{1'b0}}};
    div_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_sub = div_sh - {1'b0, mcand};
    acc_nxt = is_div(op_q)
      ? {div_sub[XLEN] ? div_sh[XLEN-1:0] : div_sub[XLEN-1:0], acc[XLEN-2:0], ~div_sub[XLEN]}
      : {mul_sum, acc[XLEN-1:1]};
  end
  // sign fix and half selection of the final product, quotient or remainder
  always_comb begin
    fix_in  = is_div(op_q) ? {{XLEN{1'b0}}, is_rem(op_q) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]} : acc;
    fix_res = (is_div(op_q) || op_q == MD_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
  end
  muldiv_negate #(.W(2*XLEN)) u_neg_fix (.din(fix_in), .neg(neg_q), .dout(fix_out));
  // control FSM and datapath registers; special cases and fast products skip CALC and commit via FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= op;
          a_q   <= a;
          b_q   <= b;
          state <= PREP;
        end
        PREP: begin
          cnt   <= CNT_W'(XLEN);
          mcand <= is_div(op_q) ? mb : ma;
          neg_q <= !(div_zero || div_ovf) && (is_rem(op_q) ? sa : sa ^ sb);
          acc   <= div_zero ? {a_q, {XLEN{1'b1}}}
                 : div_ovf  ? {{XLEN{1'b0}}, a_q}
                 : fast     ? fast_prod
                 : {{XLEN{1'b0}}, is_div(op_q) ? ma : mb};
          state <= (div_zero || div_ovf || fast) ? FIX : CALC;
        end
        CALC: begin
          acc   <= acc_nxt;
          cnt   <= cnt - CNT_W'(1);
          state <= cnt == CNT_W'(1) ? FIX : CALC;
        end
        FIX: begin
          result <= fix_res;
          state  <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed checks of muldiv_iter (XLEN=64 and XLEN=32 instances)
module tb_muldiv_iter;
  import muldiv_pkg::*;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 66;
`endif
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 0, in_ready, out_valid, busy;
  logic [2:0]  op = '0;
  logic [63:0] a = '0, b = '0, result;
  logic        in_valid32 = 0, out_ready32 = 0, in_ready32, out_valid32, busy32;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, result32;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  muldiv_iter #(.XLEN(64)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );
  muldiv_iter #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32), .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32), .result(result32), .busy(busy32)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] res, output int lat);
    op = o; a = x; b = y; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask
  task automatic release_result();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic run_chk(input string tag, input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int          lat;
    issue(o, x, y, res, lat);
    chk(tag, res, exp);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    release_result();
  endtask
  initial begin
    logic [63:0] res;
    int          lat, seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    rst = 0;
    @(posedge clk); #1;
    run_chk("mul", MD_MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    run_chk("mulhu", MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, MUL_LAT);
    run_chk("mulh", MD_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
    run_chk("mulhsu", MD_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
    run_chk("div", MD_DIV, -64'sd7, 64'd2, -64'sd3, 66);
    run_chk("rem", MD_REM, -64'sd7, 64'd2, -64'sd1, 66);
    run_chk("divu", MD_DIVU, 64'd7, 64'd2, 64'd3, 66);
    run_chk("remu", MD_REMU, 64'd7, 64'd2, 64'd1, 66);
    run_chk("div_by0", MD_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_chk("remu_by0", MD_REMU, 64'd5, 64'd0, 64'd5, 2);
    run_chk("div_ovf", MD_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2);
    run_chk("rem_ovf", MD_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
    issue(MD_DIVU, 64'd100, 64'd9, res, lat);
    chk("hold_first", res, 64'd11);
    op = MD_MULHU; a = 64'd3; b = 64'd4; in_valid = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    chk("hold_result", result, 64'd11);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    in_valid = 0;
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_not_accepted", 64'(busy), 64'd0);
    run_chk("b2b_remu", MD_REMU, 64'd100, 64'd9, 64'd1, 66);
    op = MD_DIV; a = 64'd1000; b = 64'd3; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_result", 64'(seen), 64'd0);
    op32 = MD_DIVU; a32 = 32'd100; b32 = 32'd7; in_valid32 = 1;
    @(posedge clk); #1;
    in_valid32 = 0;
    lat = 0;
    while (!out_valid32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("divu32", 64'(result32), 64'd14);
    chk("divu32_lat", 64'(lat), 64'd34);
    out_ready32 = 1;
    @(posedge clk); #1;
    out_ready32 = 0;
    chk("divu32_release", 64'(in_ready32), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
